// File: rtl/rca_pkg.sv
// ============================================================================
// rca_pkg : shared constants and helpers for the pipelined ripple-carry adder
// Rev 1.0
// ============================================================================
`default_nettype none

package rca_pkg;

  localparam int C_DEF_WIDTH = 16;
  localparam int C_DEF_SEG   = 4;

  function automatic int calc_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_add.sv
// ============================================================================
// seg_add : SEG-bit combinational ripple-carry adder built from FA cells
// Rev 1.0
// ============================================================================
`default_nettype none

module seg_add #(
  parameter int SEG = 4
) (
  output logic [SEG-1:0] sum,
  output logic           cout,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin
);

  logic [SEG:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[SEG];

endmodule

`default_nettype wire

// File: rtl/pipe_rca.sv
// ============================================================================
// pipe_rca : SEG-bit-per-stage pipelined ripple-carry adder/subtractor with
//            valid/ready flow control.  Rev 1.0
// ============================================================================
`default_nettype none

module pipe_rca
  import rca_pkg::*;
#(
  parameter int WIDTH = C_DEF_WIDTH,
  parameter int SEG   = C_DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = calc_stages(WIDTH, SEG);
  localparam int LAST   = STAGES - 1;

  // Per-stage registers; a/b carry the not-yet-added upper segments (skew),
  // s carries the already-completed lower sum segments.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] v_q, v_d;
  logic              ovf_q, ovf_d;

  // Stage inputs: either the fresh beat or the previous stage register.
  logic [WIDTH-1:0] stage_a [STAGES];
  logic [WIDTH-1:0] stage_b [STAGES];
  logic [WIDTH-1:0] stage_s [STAGES];
  logic             stage_c [STAGES];
  logic             stage_v [STAGES];

  logic [SEG-1:0] seg_s  [STAGES];
  logic           seg_co [STAGES];

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             advance;

  // Subtraction folds into the operand at entry so sub travels with the beat.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
  assign advance = !v_q[LAST] || out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stage_a[k] = a;
      assign stage_b[k] = b_eff;
      assign stage_s[k] = '0;
      assign stage_c[k] = cin_eff;
      assign stage_v[k] = in_valid;
    end else begin : g_rest
      assign stage_a[k] = a_q[k-1];
      assign stage_b[k] = b_q[k-1];
      assign stage_s[k] = s_q[k-1];
      assign stage_c[k] = c_q[k-1];
      assign stage_v[k] = v_q[k-1];
    end

    seg_add #(
      .SEG (SEG)
    ) u_seg_add (
      .sum  (seg_s[k]),
      .cout (seg_co[k]),
      .a    (stage_a[k][k*SEG +: SEG]),
      .b    (stage_b[k][k*SEG +: SEG]),
      .cin  (stage_c[k])
    );
  end

  always_comb begin
    c_d   = '0;
    v_d   = '0;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]               = stage_a[k];
      b_d[k]               = stage_b[k];
      s_d[k]               = stage_s[k];
      s_d[k][k*SEG +: SEG] = seg_s[k];
      c_d[k]               = seg_co[k];
      v_d[k]               = stage_v[k];
    end
    // Carry into the MSB is recovered from the MSB's own sum bit.
    ovf_d = (stage_a[LAST][WIDTH-1] ^ stage_b[LAST][WIDTH-1] ^ seg_s[LAST][SEG-1])
            ^ seg_co[LAST];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  // The final stage's skew copies have no consumer.
  logic unused_skew;
  assign unused_skew = ^{a_q[LAST], b_q[LAST]};

  assign in_ready  = advance;
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

endmodule

`default_nettype wire
